cla4_clkd: RTL and testbench
============================

CLA4_CLKD -- requirements
Module: cla4_clkd

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width; only 4 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 a_in  input  4  addend A, unsigned.
REQ-005 b_in  input  4  addend B, unsigned.
REQ-006 c_in  input  1  carry-in.
REQ-007 s  output  4  registered sum bits of A + B + c_in.
REQ-008 c_out  output  1  registered carry-out, bit 4 of A + B + c_in.

Function
REQ-009 {c_out, s} SHALL equal the 5-bit unsigned value a_in + b_in + c_in, with no truncation beyond 5 bits.
REQ-010 Input stage: a_in, b_in, c_in SHALL be captured into input registers on every rising edge when reset is low.
REQ-011 Adder core SHALL be a combinational 4-bit carry-lookahead adder operating on the input registers: g_i = a_i & b_i, p_i = a_i ^ b_i.
REQ-012 Carries SHALL be computed in lookahead form: c1 = g0 | p0c0; c2 = g1 | p1g0 | p1p0c0; c3 and c4 expanded likewise; no ripple chain between bits.
REQ-013 Sum bits SHALL be s_i = p_i ^ c_i; c_out SHALL be c4.
REQ-014 Output stage: s and c_out SHALL be registered on the rising edge following the input capture.
REQ-015 Latency SHALL be exactly 2 rising edges from input sample to output update; throughput one new operand set per cycle.
REQ-016 Consecutive operand sets SHALL be pipelined without interaction; each output corresponds to exactly the operands sampled two edges earlier.
REQ-017 No handshake, no valid signal; outputs SHALL hold their value between edges.
REQ-018 Wrap-around: overflow of the 4-bit sum SHALL appear only on c_out (e.g. F+1+1 -> s=1, c_out=1).
REQ-019 Inputs that are X/Z SHALL not be required to produce defined outputs; all-known inputs SHALL always give known outputs after latency.

Reset
REQ-020 While reset is high at a rising edge, input registers and output registers SHALL be cleared to 0 (s=0000, c_out=0).
REQ-021 Reset asserted mid-stream SHALL discard all in-flight operands; the first valid result after reset release SHALL appear 2 edges after the first non-reset sample.
REQ-022 Reset SHALL have priority over data capture; no asynchronous path from reset to any register.

Structure
REQ-023 No shared package is required; WIDTH is a module parameter.
REQ-024 The combinational adder SHALL be one sub-module, cla4 (a, b, cin -> sum, cout), instantiated between the input and output register stages.
REQ-025 Register stages SHALL live in the top module so the reg-to-reg path through cla4 is the timing-critical path for slack analysis.

Verification
REQ-026 Reset high for 2 edges -> s=0000, c_out=0; then release and check outputs remain 0 until first operands propagate.
REQ-027 a=1010, b=0101, c_in=0 held >=2 cycles -> s=1111, c_out=0.
REQ-028 a=1111, b=0001, c_in=1 -> s=0001, c_out=1.
REQ-029 a=0000, b=1111, c_in=0 -> s=1111, c_out=0; a=1001, b=1001, c_in=1 -> s=0011, c_out=1.
REQ-030 Back-to-back new operands every cycle (above four vectors) -> each result appears exactly 2 edges after its inputs, in order.
REQ-031 Exhaustive 512-combination sweep vs. reference model a+b+c_in, plus reset asserted mid-sweep -> outputs 0 next edge, correct results resume 2 edges after release.

Source files
------------

// File: rtl/cla4_clkd_pkg.sv
// Shared width and operand-bundle definitions for the registered 4-bit CLA.
package cla4_clkd_pkg;

    localparam int CLA_WIDTH = 4;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] a;
        logic [CLA_WIDTH-1:0] b;
        logic                 cin;
    } cla_operands_t;

endpackage

// File: rtl/cla4_clkd_cla4.sv
// Combinational 4-bit carry-lookahead adder; every carry is a flat sum of
// products of generate/propagate terms, so no carry depends on another carry.
module cla4
    import cla4_clkd_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla4_clkd.sv
// Two-stage registered adder: input capture, CLA core, output register.
// Both register stages sit here so the reg-to-reg path runs through cla4.
module cla4_clkd
    import cla4_clkd_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    cla_operands_t    ops_q;
    logic [WIDTH-1:0] sum_comb;
    logic             cout_comb;

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q <= '0;
        end else begin
            ops_q.a   <= a_in;
            ops_q.b   <= b_in;
            ops_q.cin <= c_in;
        end
    end

    cla4 #(
        .WIDTH (WIDTH)
    ) u_cla4 (
        .a    (ops_q.a),
        .b    (ops_q.b),
        .cin  (ops_q.cin),
        .sum  (sum_comb),
        .cout (cout_comb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s     <= '0;
            c_out <= 1'b0;
        end else begin
            s     <= sum_comb;
            c_out <= cout_comb;
        end
    end

endmodule

// File: tb/tb_cla4_clkd.sv
// Bench for cla4_clkd: two-deep arithmetic pipeline model checked every cycle,
// plus literal checks for the directed vectors and reset behaviour.
module tb_cla4_clkd;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       c_in;
    logic [3:0] s;
    logic       c_out;

    int n_vec  = 0;
    int n_miss = 0;

    // model: sum of operands captured last edge, and the visible output
    logic [4:0] mdl_stage;
    logic [4:0] mdl_out;
    logic       mdl_known = 1'b0;

    cla4_clkd #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .s     (s),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got c_out,s=%b, expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mdl_out   = 5'd0;
            mdl_stage = 5'd0;
            mdl_known = 1'b1;
        end else begin
            mdl_out   = mdl_stage;
            mdl_stage = 5'(a_in) + 5'(b_in) + 5'(c_in);
        end
    end

    always @(negedge clk) begin
        if (mdl_known) check("pipeline", {c_out, s}, mdl_out);
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic r);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        reset = r;
    endtask

    logic [3:0] va [4] = '{4'b1010, 4'b1111, 4'b0000, 4'b1001};
    logic [3:0] vb [4] = '{4'b0101, 4'b0001, 4'b1111, 4'b1001};
    logic       vc [4] = '{1'b0,    1'b1,    1'b0,    1'b1};
    logic [4:0] vr [4] = '{5'b01111, 5'b10001, 5'b01111, 5'b10011};

    initial begin
        reset = 1'b1;
        a_in  = 4'hF;
        b_in  = 4'hF;
        c_in  = 1'b1;

        // reset for two edges with nonzero inputs present
        @(negedge clk);
        check("reset_edge1", {c_out, s}, 5'd0);
        @(negedge clk);
        check("reset_edge2", {c_out, s}, 5'd0);

        // release; first sample needs two edges, output stays 0 meanwhile
        reset = 1'b0;
        a_in = 4'b1010; b_in = 4'b0101; c_in = 1'b0;
        @(negedge clk);
        check("post_release_zero", {c_out, s}, 5'd0);
        @(negedge clk);
        check("held_1010_0101", {c_out, s}, 5'b01111);
        check("model_1010_0101", mdl_out, 5'b01111);

        // each directed vector held for two cycles
        for (int i = 1; i < 4; i++) begin
            drive(va[i], vb[i], vc[i], 1'b0);
            @(negedge clk);
            @(negedge clk);
            check("held_vec", {c_out, s}, vr[i]);
            check("model_vec", mdl_out, vr[i]);
        end

        // back-to-back: result i visible at the negedge two after it was driven
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) check("b2b_order", {c_out, s}, vr[i-2]);
            if (i < 4) begin
                a_in = va[i]; b_in = vb[i]; c_in = vc[i];
            end
        end

        // exhaustive sweep with reset pulse in the middle
        for (int k = 0; k < 512; k++) begin
            drive(k[3:0], k[7:4], k[8], 1'b0);
            if (k == 200) begin
                drive(4'hF, 4'hF, 1'b1, 1'b1);
                @(negedge clk);
                check("midsweep_reset", {c_out, s}, 5'd0);
                drive(4'hF, 4'hF, 1'b1, 1'b0);
                @(negedge clk);
                check("resume_first_zero", {c_out, s}, 5'd0);
                @(negedge clk);
                check("resume_result", {c_out, s}, 5'b11111);
            end
        end

        // random operands with occasional reset
        for (int k = 0; k < 300; k++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end
        drive(4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
